bram_write_arbiter: RTL and testbench

//  Shares one BRAM write port among NUM_REQ write engines. Each engine posts a

---
 rtl/bram_write_arbiter.sv | 127 ++++++++++++
 tb/tb_bram_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter sharing one BRAM write port among NUM_REQ write engines.
// Each grant covers a whole op, so lines of different ops never interleave.
module bram_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_offset,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_length,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              wr_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]              wr_ready,
  output logic [NUM_REQ-1:0]              op_done,
  output logic                            bram_we,
  output logic [ADDR_WIDTH-1:0]           bram_waddr,
  output logic [DATA_WIDTH-1:0]           bram_wdata,
  output logic                            busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                  state;
  logic [IdxW-1:0]         rr_ptr;
  logic [IdxW-1:0]         owner;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   length;
  logic [ADDR_WIDTH-1:0]   count;

  logic                    grant_found;
  logic [IdxW-1:0]         grant_idx;
  logic [IdxW-1:0]         rr_next;
  logic [ADDR_WIDTH-1:0]   grant_offset;
  logic [ADDR_WIDTH-1:0]   grant_length;
  logic                    accept;
  logic                    last_line;
  logic [DATA_WIDTH-1:0]   owner_data;

  // Scan from the far end back toward rr_ptr so the closest pending requester wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IdxW'((int'(rr_ptr) + k) % int'(NUM_REQ));
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_next      = (grant_idx == IdxLast) ? '0 : grant_idx + IdxOne;
    grant_offset = req_offset[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    grant_length = req_length[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    owner_data   = wr_data[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
    accept       = (state == StStream) && wr_valid[owner];
    last_line    = (count == length - AddrOne);
  end

  always_comb begin
    req_ready = '0;
    wr_ready  = '0;
    if (!reset) begin
      if (state == StIdle && grant_found) req_ready[grant_idx] = 1'b1;
      if (state == StStream)              wr_ready[owner]      = 1'b1;
    end
  end

  assign busy = (state == StStream);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      rr_ptr     <= '0;
      owner      <= '0;
      offset     <= '0;
      length     <= '0;
      count      <= '0;
      op_done    <= '0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
    end else begin
      bram_we <= 1'b0;
      op_done <= '0;
      unique case (state)
        StIdle: begin
          if (grant_found) begin
            offset <= grant_offset;
            length <= grant_length;
            owner  <= grant_idx;
            count  <= '0;
            rr_ptr <= rr_next;
            // Zero-length ops complete immediately without touching the BRAM.
            if (grant_length == '0) op_done[grant_idx] <= 1'b1;
            else                    state <= StStream;
          end
        end
        StStream: begin
          if (accept) begin
            bram_we    <= 1'b1;
            bram_waddr <= offset + count;
            bram_wdata <= owner_data;
            count      <= count + AddrOne;
            if (last_line) begin
              op_done[owner] <= 1'b1;
              state          <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Bench for bram_write_arbiter: directed scenarios plus random traffic, checked against
// an op-level model (round-robin grant order, per-op expected write list).
module tb_bram_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_offset;
  logic [N*AW-1:0]   req_length;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      wr_valid;
  logic [N*DW-1:0]   wr_data;
  logic [N-1:0]      wr_ready;
  logic [N-1:0]      op_done;
  logic              bram_we;
  logic [AW-1:0]     bram_waddr;
  logic [DW-1:0]     bram_wdata;
  logic              busy;

  bram_write_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_offset(req_offset),
    .req_length(req_length),
    .req_ready (req_ready),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .op_done   (op_done),
    .bram_we   (bram_we),
    .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int total = 0;
  int bad   = 0;

  // Engine side: one outstanding op per engine, its data lines queued at post time.
  bit            eng_posted [N];
  logic [AW-1:0] eng_off    [N];
  logic [AW-1:0] eng_len    [N];
  logic [DW-1:0] eng_lines  [N][$];
  bit            eng_wv     [N];

  // Op-level model.
  bit            m_stream;
  int            m_rr;
  int            m_owner;
  int            m_rem;
  wr_t           exp_q[$];
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eng_busy(input int i);
    return eng_posted[i] || (eng_lines[i].size() != 0);
  endfunction

  task automatic post(input int i, input logic [AW-1:0] off, input logic [AW-1:0] len);
    if (eng_busy(i)) return;
    eng_posted[i] = 1'b1;
    eng_off[i]    = off;
    eng_len[i]    = len;
    for (int k = 0; k < int'(len); k++) eng_lines[i].push_back({$urandom, $urandom});
  endtask

  task automatic step(input bit rst);
    int           g;
    logic [N-1:0] exp_rr, exp_wr, n_done;
    bit           n_we;
    wr_t          w;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = eng_posted[i];
      req_offset[i*AW +: AW]  = eng_off[i];
      req_length[i*AW +: AW]  = eng_len[i];
      wr_valid[i]             = eng_wv[i] && (eng_lines[i].size() != 0);
      wr_data[i*DW +: DW]     = (eng_lines[i].size() != 0) ? eng_lines[i][0] : '0;
    end
    #1;
    g = -1;
    exp_rr = '0;
    exp_wr = '0;
    if (!rst) begin
      if (!m_stream) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && eng_posted[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) exp_rr[g] = 1'b1;
      end else begin
        exp_wr[m_owner] = 1'b1;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("wr_ready", 64'(wr_ready), 64'(exp_wr));
    chk("busy", 64'(busy), 64'(m_stream));
    chk("bram_we", 64'(bram_we), 64'(e_we));
    chk("bram_waddr", 64'(bram_waddr), 64'(e_addr));
    if (e_we) chk("bram_wdata", 64'(bram_wdata), 64'(e_data));
    chk("op_done", 64'(op_done), 64'(e_done));

    n_we   = 1'b0;
    n_done = '0;
    if (rst) begin
      m_stream = 1'b0;
      m_rr     = 0;
      e_addr   = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        eng_posted[i] = 1'b0;
        eng_lines[i].delete();
      end
    end else if (!m_stream) begin
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        eng_posted[g] = 1'b0;
        if (eng_len[g] == '0) begin
          n_done[g] = 1'b1;
        end else begin
          m_stream = 1'b1;
          m_owner  = g;
          m_rem    = int'(eng_len[g]);
          for (int k = 0; k < int'(eng_len[g]); k++) begin
            w.a = eng_off[g] + AW'(k);
            w.d = eng_lines[g][k];
            exp_q.push_back(w);
          end
        end
      end
    end else if (wr_valid[m_owner] && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      n_we   = 1'b1;
      e_addr = w.a;
      e_data = w.d;
      void'(eng_lines[m_owner].pop_front());
      m_rem--;
      if (m_rem == 0) begin
        n_done[m_owner] = 1'b1;
        m_stream = 1'b0;
      end
    end
    e_we   = n_we;
    e_done = n_done;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int  cyc;
    bit  pending;
    cyc = 0;
    pending = 1'b1;
    while (pending && cyc < 300) begin
      pending = m_stream;
      for (int i = 0; i < N; i++) if (eng_busy(i)) pending = 1'b1;
      if (pending) begin
        step(1'b0);
        cyc++;
      end
    end
    if (pending) begin
      total++;
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=<300", cyc);
    end
    step(1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_offset = '0;
    req_length = '0;
    wr_valid   = '0;
    wr_data    = '0;
    for (int i = 0; i < N; i++) begin
      eng_posted[i] = 1'b0;
      eng_off[i]    = '0;
      eng_len[i]    = '0;
      eng_wv[i]     = 1'b1;
    end
    m_stream = 1'b0;
    m_rr     = 0;
    m_owner  = 0;
    m_rem    = 0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    e_done   = '0;
    @(posedge clk);
    @(negedge clk);
    step(1'b1);

    // Single op, data always valid.
    post(0, 16'h0010, 16'd4);
    repeat (8) step(1'b0);

    // All four requesters pending from reset, then requester 0 again.
    step(1'b1);
    for (int i = 0; i < N; i++) post(i, AW'(16'h1000 * (i + 1)), 16'd2);
    drain();
    post(0, 16'h0020, 16'd2);
    drain();

    // Zero-length op, then two contenders to expose the pointer position.
    post(1, 16'h0040, 16'd0);
    drain();
    post(0, 16'h0050, 16'd1);
    post(2, 16'h0060, 16'd1);
    drain();

    // Owner valid toggles while a stalled contender keeps valid high.
    post(1, 16'h0100, 16'd3);
    post(2, 16'h0200, 16'd2);
    for (int c = 0; c < 10; c++) begin
      eng_wv[1] = c[0];
      step(1'b0);
    end
    eng_wv[1] = 1'b1;
    drain();

    // Address wrap.
    post(3, 16'hFFFE, 16'd4);
    drain();

    // Reset after two lines of a five-line op, then a fresh op.
    post(0, 16'h0300, 16'd5);
    repeat (3) step(1'b0);
    step(1'b1);
    step(1'b0);
    post(0, 16'h0300, 16'd5);
    drain();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        eng_wv[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0)
          post(i, AW'($urandom), AW'($urandom_range(0, 5)));
      end
      step(1'b0);
    end
    for (int i = 0; i < N; i++) eng_wv[i] = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
